board_scan: RTL and testbench

- Reader counterpart to mem_reset. On request, walks all 64 cells of checkerboard_state_ram through one read port and streams each cell out over a valid/ready interface.
- Accumulates per-state stone counts while it scans. Used for board dump to the host, post-reset verification and end-of-game scoring.
- Sits beside mem_reset on the RAM. It only reads, so it can share the RAM with a write-side client without arbitration.

---
 rtl/board_scan_if.sv | 11 +
 rtl/board_scan.sv | 135 +++++++++++++
 tb/tb_board_scan.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/board_scan_if.sv
// Cell-record stream from board_scan to its consumer.
// Handshake: a record transfers on a rising clk edge with out_valid && out_ready; while out_valid is high and out_ready low, out_addr/out_data hold stable.
interface board_scan_if;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_addr;
    logic [1:0] out_data;

    modport master (output out_valid, output out_addr, output out_data, input out_ready);
    modport slave  (input out_valid, input out_addr, input out_data, output out_ready);
endinterface

// File: rtl/board_scan.sv
// Read-only board scanner: walks every RAM cell, streams (addr, data) records and
// tallies empty/black/white/invalid codes along the way.
module board_scan #(
    parameter int RD_LATENCY = 1,
    parameter int CELLS      = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [5:0]   ram_rd_addr,
    input  logic [1:0]   ram_rd_data,
    board_scan_if.master rec,
    output logic [6:0]   cnt_empty,
    output logic [6:0]   cnt_black,
    output logic [6:0]   cnt_white,
    output logic [6:0]   cnt_invalid,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_OUT   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [5:0] rd_addr_q, rd_addr_d;
    logic [5:0] out_addr_q, out_addr_d;
    logic [1:0] out_data_q, out_data_d;
    logic [1:0] wait_q, wait_d;
    logic [6:0] cnt_q [4];
    logic [6:0] cnt_d [4];
    logic       wait_last;
    logic       last_cell;

    assign wait_last = (wait_q == 2'(RD_LATENCY));
    assign last_cell = (idx_q == 6'(CELLS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Dropping en anywhere mid-scan aborts straight to IDLE, ahead of any capture or handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_ISSUE;
            S_ISSUE: if (!en) state_d = S_IDLE;
                     else if (wait_last) state_d = S_OUT;
            S_OUT:   if (!en) state_d = S_IDLE;
                     else if (rec.out_ready) state_d = last_cell ? S_DONE : S_ISSUE;
            S_DONE:  if (!en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        wait_d     = wait_q;
        rd_addr_d  = rd_addr_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
        case (state_q)
            S_IDLE: if (en) begin
                idx_d  = '0;
                wait_d = '0;
                for (int i = 0; i < 4; i++) cnt_d[i] = '0;
            end
            S_ISSUE: if (en) begin
                if (wait_last) begin
                    out_addr_d              = idx_q;
                    out_data_d              = ram_rd_data;
                    cnt_d[ram_rd_data]      = cnt_q[ram_rd_data] + 7'd1;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_OUT: if (en && rec.out_ready && !last_cell) begin
                idx_d     = idx_q + 6'd1;
                rd_addr_d = idx_q + 6'd1;
                wait_d    = '0;
            end
            default: ;
        endcase
        // The read address moves only when a new ISSUE starts, so a registered RAM sees it stable.
        if (state_d == S_IDLE) rd_addr_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            wait_q     <= '0;
            rd_addr_q  <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            rd_addr_q  <= rd_addr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        rec.out_valid = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            S_ISSUE: busy = 1'b1;
            S_OUT: begin
                busy          = 1'b1;
                rec.out_valid = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign rec.out_addr = out_addr_q;
    assign rec.out_data = out_data_q;
    assign ram_rd_addr  = rd_addr_q;
    assign cnt_empty    = cnt_q[0];
    assign cnt_black    = cnt_q[1];
    assign cnt_white    = cnt_q[2];
    assign cnt_invalid  = cnt_q[3];
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_board_scan.sv
// Bench for board_scan: one instance on a registered-read RAM, one on a combinational-read RAM,
// both fed from the same board array; records and counts are checked against a board-level model.
module tb_board_scan;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic       ready;
    logic       sel;
    logic [1:0] mem [64];
    logic [7:0] exp_q [$];
    int         n_assert;
    int         n_fail;

    board_scan_if if1 ();
    board_scan_if if0 ();

    logic       en1, en0;
    logic [5:0] a1, a0;
    logic [1:0] rd1, rd0;
    logic [6:0] ce1, cb1, cw1, ci1, ce0, cb0, cw0, ci0;
    logic       busy1, done1, busy0, done0;
    logic [1:0] st1, st0;

    assign en1          = en & sel;
    assign en0          = en & ~sel;
    assign if1.out_ready = ready & sel;
    assign if0.out_ready = ready & ~sel;

    always @(posedge clk) rd1 <= mem[a1];
    assign rd0 = mem[a0];

    board_scan #(.RD_LATENCY(1), .CELLS(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .ram_rd_addr(a1), .ram_rd_data(rd1), .rec(if1),
        .cnt_empty(ce1), .cnt_black(cb1), .cnt_white(cw1), .cnt_invalid(ci1),
        .busy(busy1), .done(done1), .dbg_state(st1)
    );
    board_scan #(.RD_LATENCY(0), .CELLS(64)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .ram_rd_addr(a0), .ram_rd_data(rd0), .rec(if0),
        .cnt_empty(ce0), .cnt_black(cb0), .cnt_white(cw0), .cnt_invalid(ci0),
        .busy(busy0), .done(done0), .dbg_state(st0)
    );

    logic        cur_valid, cur_busy, cur_done;
    logic [5:0]  cur_addr, cur_rda;
    logic [1:0]  cur_data, cur_st;
    logic [27:0] cur_cnts;
    always_comb begin
        cur_valid = sel ? if1.out_valid : if0.out_valid;
        cur_addr  = sel ? if1.out_addr  : if0.out_addr;
        cur_data  = sel ? if1.out_data  : if0.out_data;
        cur_rda   = sel ? a1 : a0;
        cur_busy  = sel ? busy1 : busy0;
        cur_done  = sel ? done1 : done0;
        cur_st    = sel ? st1 : st0;
        cur_cnts  = sel ? {ce1, cb1, cw1, ci1} : {ce0, cb0, cw0, ci0};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Number of cells 0..last holding code c.
    function automatic int cnt_of(input int c, input int last);
        int n = 0;
        for (int i = 0; i <= last; i++) if (int'(mem[i]) == c) n++;
        return n;
    endfunction

    function automatic logic [27:0] model_cnts(input int last);
        return {7'(cnt_of(0, last)), 7'(cnt_of(1, last)), 7'(cnt_of(2, last)), 7'(cnt_of(3, last))};
    endfunction

    task automatic scan(input bit bp, input int abort_at, input int exp_cyc, input bit hold_chk);
        int         cyc = 0;
        int         stall = 0;
        bit         pv = 0, pr = 0;
        logic [5:0] pa = '0;
        logic [1:0] pd = '0;
        logic [7:0] e;
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), mem[i]});
        @(negedge clk);
        en = 1'b1;
        ready = 1'b0;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("start_cnt_clear", cur_cnts, 28'd0);
                chk("start_busy", cur_busy, 1);
            end
            if (pv && !pr) begin
                chk("stall_valid", cur_valid, 1);
                chk("stall_addr", cur_addr, pa);
                chk("stall_data", cur_data, pd);
            end
            if (cur_done) break;
            if (abort_at >= 0 && cur_valid && cur_addr == 6'(abort_at)) begin
                en = 1'b0;
                ready = 1'b0;
                @(negedge clk);
                chk("abort_valid", cur_valid, 0);
                chk("abort_busy", cur_busy, 0);
                chk("abort_done", cur_done, 0);
                chk("abort_rd_addr", cur_rda, 0);
                chk("abort_cnts", cur_cnts, model_cnts(abort_at));
                repeat (3) @(negedge clk);
                chk("abort_done_later", cur_done, 0);
                return;
            end
            if (bp && cur_valid && cur_addr == 6'd31 && stall < 10) begin
                ready = 1'b0;
                stall++;
            end else begin
                ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (cur_valid && ready) begin
                if (exp_q.size() == 0) chk("extra_record", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rec_addr", cur_addr, e[7:2]);
                    chk("rec_data", cur_data, e[1:0]);
                end
            end
            pv = cur_valid; pr = ready; pa = cur_addr; pd = cur_data;
        end
        chk("done_seen", cur_done, 1);
        chk("all_delivered", exp_q.size(), 0);
        if (exp_cyc > 0) chk("done_latency", cyc, exp_cyc);
        chk("done_cnts", cur_cnts, model_cnts(63));
        chk("cnt_sum", cur_cnts[27:21] + cur_cnts[20:14] + cur_cnts[13:7] + cur_cnts[6:0], 64);
        if (hold_chk) begin
            repeat (5) begin
                @(negedge clk);
                chk("hold_done", cur_done, 1);
                chk("hold_cnts", cur_cnts, model_cnts(63));
            end
        end
        en = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        chk("done_drop", cur_done, 0);
        chk("idle_busy", cur_busy, 0);
        chk("idle_rd_addr", cur_rda, 0);
        chk("idle_cnts_kept", cur_cnts, model_cnts(63));
    endtask

    task automatic reset_state_chk(input string tag);
        chk({tag, "_valid"}, cur_valid, 0);
        chk({tag, "_busy"}, cur_busy, 0);
        chk({tag, "_done"}, cur_done, 0);
        chk({tag, "_rd_addr"}, cur_rda, 0);
        chk({tag, "_addr"}, cur_addr, 0);
        chk({tag, "_data"}, cur_data, 0);
        chk({tag, "_cnts"}, cur_cnts, 0);
        chk({tag, "_state"}, cur_st, 0);
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst_n = 1'b0;
        en = 1'b0;
        ready = 1'b0;
        sel = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 2'($urandom_range(0, 3));
        repeat (3) @(negedge clk);
        reset_state_chk("reset_lat1");
        sel = 1'b0;
        #1;
        reset_state_chk("reset_lat0");
        @(negedge clk);
        rst_n = 1'b1;
        sel = 1'b1;

        // Board cleared after random contents, steady consumer, done timing and hold.
        for (int i = 0; i < 64; i++) mem[i] = 2'b00;
        scan(0, -1, 64 * 3 + 1, 1);
        chk("clear_empty", cur_cnts[27:21], 64);

        // Repeating 0/1/2 pattern under random backpressure with a long stall at 31.
        for (int i = 0; i < 64; i++) mem[i] = 2'(i % 3);
        scan(1, -1, 0, 0);
        chk("pattern_cnts", cur_cnts, {7'd22, 7'd21, 7'd21, 7'd0});

        // Invalid codes at both a middle cell and the last cell.
        for (int i = 0; i < 64; i++) mem[i] = 2'b01;
        mem[5] = 2'b11;
        mem[63] = 2'b11;
        scan(1, -1, 0, 0);
        chk("invalid_cnts", cur_cnts, {7'd0, 7'd62, 7'd0, 7'd2});

        // Abort at cell 20, then a full restart on a random board.
        for (int i = 0; i < 64; i++) mem[i] = 2'($urandom_range(0, 3));
        scan(1, 20, 0, 0);
        scan(1, -1, 0, 0);

        // Combinational-read instance: same pattern, two cycles per cell.
        sel = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 2'(i % 3);
        scan(0, -1, 64 * 2 + 1, 1);
        chk("lat0_pattern_cnts", cur_cnts, {7'd22, 7'd21, 7'd21, 7'd0});
        for (int i = 0; i < 64; i++) mem[i] = 2'($urandom_range(0, 3));
        scan(1, -1, 0, 0);

        // Reset asserted in the middle of a scan.
        sel = 1'b1;
        @(negedge clk);
        en = 1'b1;
        ready = 1'b1;
        repeat (50) @(negedge clk);
        chk("midscan_busy", cur_busy, 1);
        rst_n = 1'b0;
        #1;
        reset_state_chk("midscan_reset");
        en = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reset_state_chk("post_reset_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
